// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcodes, ALU ops, sequencer states and instruction classes for control_unit
// Used by cu_opdecode and control_unit (CU_MULDIV_EN selects mul/div support in cu_opdecode).
package cu_pkg;

  localparam logic [4:0] OP_LD     = 5'b00000;
  localparam logic [4:0] OP_LDI    = 5'b00001;
  localparam logic [4:0] OP_ST     = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_AND    = 5'b00101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_ROR    = 5'b00111;
  localparam logic [4:0] OP_ROL    = 5'b01000;
  localparam logic [4:0] OP_SHR    = 5'b01001;
  localparam logic [4:0] OP_SHRA   = 5'b01010;
  localparam logic [4:0] OP_SHL    = 5'b01011;
  localparam logic [4:0] OP_ADDI   = 5'b01100;
  localparam logic [4:0] OP_ANDI   = 5'b01101;
  localparam logic [4:0] OP_ORI    = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_NEG    = 5'b10001;
  localparam logic [4:0] OP_NOT    = 5'b10010;
  localparam logic [4:0] OP_BRANCH = 5'b10011;
  localparam logic [4:0] OP_JR     = 5'b10100;
  localparam logic [4:0] OP_IN     = 5'b10110;
  localparam logic [4:0] OP_OUT    = 5'b10111;
  localparam logic [4:0] OP_MFHI   = 5'b11000;
  localparam logic [4:0] OP_MFLO   = 5'b11001;
  localparam logic [4:0] OP_NOP    = 5'b11010;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  localparam logic [4:0] ALU_NONE  = 5'b00000;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_AND   = 5'b00101;
  localparam logic [4:0] ALU_OR    = 5'b00110;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LDI, CLS_LD, CLS_ST,
    CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_HALT
  } iclass_e;

  // Final execute step of each class; the sequencer wraps to T0 after it.
  function automatic state_e last_step(input iclass_e cls);
    case (cls)
      CLS_ALU, CLS_IMM, CLS_LDI: last_step = ST_T5;
      CLS_UNARY:                 last_step = ST_T4;
      CLS_MULDIV, CLS_BR:        last_step = ST_T6;
      CLS_LD, CLS_ST:            last_step = ST_T7;
      default:                   last_step = ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_opdecode.sv
// rtl/cu_opdecode.sv - opcode to instruction class and ALU opcode
// mul/div decode as nop unless CU_MULDIV_EN is defined.
module cu_opdecode
  import cu_pkg::*;
(
  input  logic [4:0] op_i,
  output iclass_e    class_o,
  output logic [4:0] alu_op_o
);

  always_comb begin
    class_o  = CLS_NOP;
    alu_op_o = ALU_NONE;
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        class_o  = CLS_ALU;
        alu_op_o = op_i;
      end
      OP_ADDI: begin class_o = CLS_IMM; alu_op_o = ALU_ADD; end
      OP_ANDI: begin class_o = CLS_IMM; alu_op_o = ALU_AND; end
      OP_ORI:  begin class_o = CLS_IMM; alu_op_o = ALU_OR;  end
      OP_NEG, OP_NOT: begin
        class_o  = CLS_UNARY;
        alu_op_o = op_i;
      end
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV: begin
        class_o  = CLS_MULDIV;
        alu_op_o = op_i;
      end
`else
      OP_MUL, OP_DIV: class_o = CLS_NOP;
`endif
      OP_LDI:    begin class_o = CLS_LDI; alu_op_o = ALU_ADD; end
      OP_LD:     begin class_o = CLS_LD;  alu_op_o = ALU_ADD; end
      OP_ST:     begin class_o = CLS_ST;  alu_op_o = ALU_ADD; end
      OP_BRANCH: begin class_o = CLS_BR;  alu_op_o = ALU_ADD; end
      OP_JR:     class_o = CLS_JR;
      OP_IN:     class_o = CLS_IN;
      OP_OUT:    class_o = CLS_OUT;
      OP_MFHI:   class_o = CLS_MFHI;
      OP_MFLO:   class_o = CLS_MFLO;
      OP_HALT:   class_o = CLS_HALT;
      default:   class_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute sequencer driving the datapath strobes
// Optional mul/div sequences are enabled by CU_MULDIV_EN (see cu_opdecode).
module control_unit
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        CON_out,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortin,
  output logic        CON_in,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  operation,
  output logic        Run
);

  state_e     state_q, state_d;
  logic       run_q;
  iclass_e    cls;
  logic [4:0] alu_op;
  logic       unused_ir;

  // Register fields are routed to the register file by the datapath, not here.
  assign unused_ir = ^IR[26:0];

  cu_opdecode u_opdecode (
    .op_i     (IR[31:27]),
    .class_o  (cls),
    .alu_op_o (alu_op)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_RST;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d != ST_RST) && (state_d != ST_HALT);
    end
  end

  assign Run = run_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_HALT: state_d = ST_HALT;
      default: begin
        if (state_q == last_step(cls))
          state_d = (cls == CLS_HALT) ? ST_HALT : ST_T0;
        else
          state_d = state_e'(4'(state_q) + 4'd1);
      end
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CON_in = 1'b0;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    operation = ALU_NONE;
    case (state_q)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_IMM: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_UNARY: begin GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = alu_op; end
          CLS_MULDIV: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_LDI, CLS_LD, CLS_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CLS_BR:   begin GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
          CLS_JR:   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CLS_IN:   begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_OUT:  begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          CLS_MFHI: begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_MFLO: begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_ALU: begin GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = alu_op; end
          CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin Cout = 1'b1; Zin = 1'b1; operation = alu_op; end
          CLS_UNARY:  begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_MULDIV: begin GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = alu_op; end
          CLS_BR:     begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_ALU, CLS_IMM, CLS_LDI: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_MULDIV:    begin Zlowout = 1'b1; LOin = 1'b1; end
          CLS_LD, CLS_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          CLS_BR:        begin Cout = 1'b1; Zin = 1'b1; operation = alu_op; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          CLS_ST:     begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CLS_BR:     begin Zlowout = 1'b1; PCin = CON_out; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against a step-table model
// Define CU_MULDIV_EN for both bench and RTL to check the mul/div sequences.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] IR;
  logic        CON_out;
  logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CON_in;
  logic GRA, GRB, GRC, Rin, Rout, BAout, IncPC, Read, Write;
  logic [4:0] operation;
  logic Run;

`ifdef CU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  localparam logic [26:0] B_PCOUT = 27'd1 << 26, B_ZLO = 27'd1 << 25, B_ZHI = 27'd1 << 24;
  localparam logic [26:0] B_MDROUT = 27'd1 << 23, B_HIOUT = 27'd1 << 22, B_LOOUT = 27'd1 << 21;
  localparam logic [26:0] B_COUT = 27'd1 << 20, B_INP = 27'd1 << 19, B_MARIN = 27'd1 << 18;
  localparam logic [26:0] B_ZIN = 27'd1 << 17, B_PCIN = 27'd1 << 16, B_MDRIN = 27'd1 << 15;
  localparam logic [26:0] B_IRIN = 27'd1 << 14, B_YIN = 27'd1 << 13, B_HIIN = 27'd1 << 12;
  localparam logic [26:0] B_LOIN = 27'd1 << 11, B_OUTP = 27'd1 << 10, B_CONIN = 27'd1 << 9;
  localparam logic [26:0] B_GRA = 27'd1 << 8, B_GRB = 27'd1 << 7, B_GRC = 27'd1 << 6;
  localparam logic [26:0] B_RIN = 27'd1 << 5, B_ROUT = 27'd1 << 4, B_BAOUT = 27'd1 << 3;
  localparam logic [26:0] B_INCPC = 27'd1 << 2, B_READ = 27'd1 << 1, B_WRITE = 27'd1;

  int n_vec = 0;
  int n_bad = 0;

  control_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON_out(CON_out),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CON_in(CON_in),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .operation(operation), .Run(Run)
  );

  always #5 Clock = ~Clock;

  task automatic check_vec(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] obs();
    return {Run, operation, PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
            MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CON_in,
            GRA, GRB, GRC, Rin, Rout, BAout, IncPC, Read, Write};
  endfunction

  function automatic bit is_muldiv(input logic [4:0] op);
    return MULDIV && (op == 5'd15 || op == 5'd16);
  endfunction

  // Instruction length in clocks, fetch included.
  function automatic int cost(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 8;
    if (op == 5'd19 || is_muldiv(op)) return 7;
    if (op == 5'd1 || (op >= 5'd3 && op <= 5'd14)) return 6;
    if (op == 5'd17 || op == 5'd18) return 5;
    return 4;
  endfunction

  // Expected {Run, operation, strobes} for step k (0 = T0) of instruction op.
  function automatic logic [32:0] model(input logic [4:0] op, input int k, input logic con);
    logic [26:0] s = '0;
    logic [4:0]  a = '0;
    int e = k - 3;
    if (k == 0) s = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    else if (k == 1) s = B_ZLO | B_PCIN | B_READ | B_MDRIN;
    else if (k == 2) s = B_MDROUT | B_IRIN;
    else if (op >= 5'd3 && op <= 5'd14) begin
      if (e == 0) s = B_GRB | B_ROUT | B_YIN;
      if (e == 1) begin
        s = (op <= 5'd11) ? (B_GRC | B_ROUT | B_ZIN) : (B_COUT | B_ZIN);
        a = (op <= 5'd11) ? op : (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
      end
      if (e == 2) s = B_ZLO | B_GRA | B_RIN;
    end else if (op == 5'd17 || op == 5'd18) begin
      if (e == 0) begin s = B_GRB | B_ROUT | B_ZIN; a = op; end
      if (e == 1) s = B_ZLO | B_GRA | B_RIN;
    end else if (is_muldiv(op)) begin
      if (e == 0) s = B_GRA | B_ROUT | B_YIN;
      if (e == 1) begin s = B_GRB | B_ROUT | B_ZIN; a = op; end
      if (e == 2) s = B_ZLO | B_LOIN;
      if (e == 3) s = B_ZHI | B_HIIN;
    end else if (op <= 5'd2) begin
      if (e == 0) s = B_GRB | B_BAOUT | B_YIN;
      if (e == 1) begin s = B_COUT | B_ZIN; a = 5'd3; end
      if (e == 2) s = (op == 5'd1) ? (B_ZLO | B_GRA | B_RIN) : (B_ZLO | B_MARIN);
      if (e == 3) s = (op == 5'd0) ? (B_READ | B_MDRIN) : (B_GRA | B_ROUT | B_MDRIN);
      if (e == 4) s = (op == 5'd0) ? (B_MDROUT | B_GRA | B_RIN) : B_WRITE;
    end else if (op == 5'd19) begin
      if (e == 0) s = B_GRA | B_ROUT | B_CONIN;
      if (e == 1) s = B_PCOUT | B_YIN;
      if (e == 2) begin s = B_COUT | B_ZIN; a = 5'd3; end
      if (e == 3) s = B_ZLO | (con ? B_PCIN : 27'd0);
    end else begin
      case (op)
        5'd20: s = B_GRA | B_ROUT | B_PCIN;
        5'd22: s = B_INP | B_GRA | B_RIN;
        5'd23: s = B_GRA | B_ROUT | B_OUTP;
        5'd24: s = B_HIOUT | B_GRA | B_RIN;
        5'd25: s = B_LOOUT | B_GRA | B_RIN;
        default: s = '0;
      endcase
    end
    return {1'b1, a, s};
  endfunction

  // Entered just after a negedge; the next negedge falls in T0 of this instruction.
  task automatic run_instr(input logic [31:0] ir, input logic con, input string tag, input int stop_at);
    int n = cost(ir[31:27]);
    if (stop_at >= 0) n = stop_at + 1;
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      check_vec($sformatf("%s op=%0d T%0d", tag, ir[31:27], k), obs(), model(ir[31:27], k, con));
      if (k == 0) begin
        IR = $urandom;
        CON_out = 1'($urandom_range(0, 1));
      end else if (k == 2) begin
        IR = ir;
        CON_out = con;
      end
    end
  endtask

  initial begin
    logic [31:0] rir;
    logic [4:0]  rop;
    Reset_n = 1'b0;
    IR = 32'h19A38000;
    CON_out = 1'b1;
    repeat (2) @(negedge Clock);
    check_vec("reset_idle", obs(), 33'd0);
    Reset_n = 1'b1;

    run_instr(32'h19A38000, 1'b0, "add_abort", 4);
    #2 Reset_n = 1'b0;
    #1 check_vec("abort_async", obs(), 33'd0);
    @(negedge Clock);
    check_vec("abort_hold", obs(), 33'd0);
    Reset_n = 1'b1;

    run_instr(32'h19A38000, 1'b0, "add", -1);
    run_instr(32'h9A800023, 1'b1, "brzr_taken", -1);
    run_instr(32'h9A800023, 1'b0, "brzr_not", -1);
    run_instr(32'h01000055, 1'b0, "ld", -1);
    run_instr(32'h81A00000, 1'b0, "mul", -1);
    run_instr(32'h79A00000, 1'b1, "div", -1);

    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd27) rop = 5'd26;
      rir = {rop, 27'($urandom)};
      run_instr(rir, 1'($urandom_range(0, 1)), "rand", -1);
    end

    run_instr(32'hD8000000, 1'b0, "halt", -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      CON_out = 1'($urandom_range(0, 1));
      IR = $urandom;
      check_vec($sformatf("halted c%0d", i), obs(), 33'd0);
    end
    Reset_n = 1'b0;
    @(negedge Clock);
    check_vec("halt_reset", obs(), 33'd0);
    Reset_n = 1'b1;
    run_instr(32'h19A38000, 1'b0, "add_restart", -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
